// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multicycle RISC-V control path: state codes,
// opcodes, ALU operation encodings and the decoded instruction classes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'b0000,
        FETCH     = 4'b0001,
        DECODE    = 4'b0010,
        EXECUTE   = 4'b0011,
        MEM_READ  = 4'b0100,
        MEM_WRITE = 4'b0101,
        WRITEBACK = 4'b0110,
        BRANCH    = 4'b0111,
        PC_UPDATE = 4'b1000,
        HALT      = 4'b1111
    } estado_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_ILLEGAL
    } classe_t;

    // States in which the FSM waits on a ready handshake.
    function automatic logic is_wait_state(input estado_t s);
        return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
    endfunction

endpackage

// File: rtl/controle_multiciclo_decodifica.sv
// Combinational instruction classifier: opcode/funct3 -> class plus an
// illegal flag. Only beq/bne are accepted among conditional branches.
module decodifica_opcode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output classe_t    classe,
    output logic       ilegal
);

    always_comb begin
        classe = CLS_ILLEGAL;
        case (opcode)
            OP_R:      classe = CLS_R;
            OP_I:      classe = CLS_I;
            OP_LOAD:   classe = CLS_LOAD;
            OP_STORE:  classe = CLS_STORE;
            OP_BRANCH: begin
                if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                    classe = CLS_BRANCH;
                end
            end
            default:   classe = CLS_ILLEGAL;
        endcase
        ilegal = (classe == CLS_ILLEGAL);
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback,
// owns pcsrc, the handshake timeout and the instruction-retire counter.
module controle_multiciclo
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      instrucao,
    input  logic             instr_ready,
    input  logic             mem_ready,
    input  logic             zero,
    output logic [3:0]       estado,
    output logic             instr_read,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic [1:0]       alu_op,
    output logic             pcsrc,
    output logic [31:0]      ir,
    output logic             halted,
    output logic             erro,
    output logic [CNT_W-1:0] instret
);

    estado_t          state_reg, state_next;
    logic [31:0]      ir_reg;
    logic             pcsrc_reg;
    logic [CNT_W-1:0] instret_reg;
    logic             erro_reg;
    logic [31:0]      wait_cnt_reg;

    classe_t classe;
    logic    ilegal;
    logic    ready_sel;
    logic    limit_hit;
    logic    timeout;

    decodifica_opcode u_decodifica (
        .opcode (ir_reg[6:0]),
        .funct3 (ir_reg[14:12]),
        .classe (classe),
        .ilegal (ilegal)
    );

    // The handshake that matters depends on which wait state we are in.
    assign ready_sel = (state_reg == FETCH) ? instr_ready : mem_ready;
    assign limit_hit = (WAIT_LIMIT != 0) && !ready_sel &&
                       ((wait_cnt_reg + 32'd1) == WAIT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timeout    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                if (instr_ready) begin
                    state_next = DECODE;
                end else if (limit_hit) begin
                    state_next = HALT;
                    timeout    = 1'b1;
                end
            end
            DECODE: begin
                if (ilegal)                   state_next = HALT;
                else if (classe == CLS_BRANCH) state_next = BRANCH;
                else                           state_next = EXECUTE;
            end
            EXECUTE: begin
                case (classe)
                    CLS_LOAD:     state_next = MEM_READ;
                    CLS_STORE:    state_next = MEM_WRITE;
                    CLS_R, CLS_I: state_next = WRITEBACK;
                    default:      state_next = HALT;
                endcase
            end
            MEM_READ, MEM_WRITE: begin
                // A ready arriving on the limit cycle still completes normally.
                if (mem_ready) begin
                    state_next = (state_reg == MEM_READ) ? WRITEBACK : PC_UPDATE;
                end else if (limit_hit) begin
                    state_next = HALT;
                    timeout    = 1'b1;
                end
            end
            WRITEBACK: state_next = PC_UPDATE;
            BRANCH:    state_next = PC_UPDATE;
            PC_UPDATE: state_next = FETCH;
            HALT:      state_next = HALT;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_reg       <= '0;
            pcsrc_reg    <= 1'b0;
            instret_reg  <= '0;
            erro_reg     <= 1'b0;
            wait_cnt_reg <= '0;
        end else begin
            if (state_reg == FETCH && instr_ready) begin
                ir_reg <= instrucao;
            end

            // pcsrc is held from BRANCH through PC_UPDATE and cleared entering FETCH.
            if (state_reg == BRANCH) begin
                pcsrc_reg <= (ir_reg[14:12] == F3_BEQ) ? zero : ~zero;
            end else if (state_next == FETCH) begin
                pcsrc_reg <= 1'b0;
            end

            if (state_reg == PC_UPDATE) begin
                instret_reg <= instret_reg + 1'b1;
            end

            if (timeout) begin
                erro_reg <= 1'b1;
            end

            // No wait state follows another, so leaving one always zeroes the count.
            if (is_wait_state(state_reg) && !ready_sel) begin
                wait_cnt_reg <= wait_cnt_reg + 32'd1;
            end else begin
                wait_cnt_reg <= '0;
            end
        end
    end

    always_comb begin
        instr_read = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = ALUOP_ADD;
        halted     = 1'b0;
        case (state_reg)
            FETCH:     instr_read = 1'b1;
            EXECUTE: begin
                case (classe)
                    CLS_R: begin
                        alu_src = 1'b0;
                        alu_op  = ALUOP_FUNCT;
                    end
                    CLS_I: begin
                        alu_src = 1'b1;
                        alu_op  = ALUOP_FUNCT;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src = 1'b1;
                        alu_op  = ALUOP_ADD;
                    end
                    default: begin
                        alu_src = 1'b0;
                        alu_op  = ALUOP_ADD;
                    end
                endcase
            end
            MEM_READ:  mem_read  = 1'b1;
            MEM_WRITE: mem_write = 1'b1;
            WRITEBACK: begin
                reg_write  = 1'b1;
                mem_to_reg = (classe == CLS_LOAD);
            end
            BRANCH: begin
                alu_src = 1'b0;
                alu_op  = ALUOP_SUB;
            end
            HALT:      halted = 1'b1;
            default:   ;
        endcase
    end

    assign estado  = state_reg;
    assign pcsrc   = pcsrc_reg;
    assign ir      = ir_reg;
    assign erro    = erro_reg;
    assign instret = instret_reg;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Randomized bench for controle_multiciclo: a per-instruction model expands each
// instruction into its expected cycle-by-cycle control outputs and drives the handshakes.
module tb_controle_multiciclo;

    localparam int LIM   = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      instrucao = '0;
    logic             instr_ready = 1'b0;
    logic             mem_ready = 1'b0;
    logic             zero = 1'b0;
    logic [3:0]       estado;
    logic             instr_read, mem_read, mem_write, reg_write;
    logic             alu_src, mem_to_reg, pcsrc, halted, erro;
    logic [1:0]       alu_op;
    logic [31:0]      ir;
    logic [CNT_W-1:0] instret;

    controle_multiciclo #(.WAIT_LIMIT(LIM), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instrucao(instrucao),
        .instr_ready(instr_ready), .mem_ready(mem_ready), .zero(zero),
        .estado(estado), .instr_read(instr_read), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .alu_src(alu_src),
        .mem_to_reg(mem_to_reg), .alu_op(alu_op), .pcsrc(pcsrc), .ir(ir),
        .halted(halted), .erro(erro), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] est;
        logic       ird, mrd, mwr, rwr, asrc, m2r;
        logic [1:0] aop;
        logic       pcs, hlt, err;
    } ctl_t;

    typedef struct {
        ctl_t        c;
        logic [31:0] irv;
        logic [1:0]  cnt;
        logic        ir_rdy, m_rdy, z;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic        m_pcsrc = 1'b0;
    logic        m_erro = 1'b0;
    int          m_instret = 0;
    logic [31:0] m_ir = '0;

    function automatic logic rb();
        return $urandom_range(0, 1) != 0;
    endfunction

    function automatic ctl_t mk(input logic [3:0] e);
        ctl_t c;
        c     = '0;
        c.est = e;
        c.pcs = m_pcsrc;
        c.hlt = (e == 4'hF);
        c.err = m_erro;
        return c;
    endfunction

    function automatic ctl_t observe();
        return {estado, instr_read, mem_read, mem_write, reg_write, alu_src,
                mem_to_reg, alu_op, pcsrc, halted, erro};
    endfunction

    task automatic push(input ctl_t c, input logic ir_rdy, input logic m_rdy,
                        input logic z, input logic [31:0] instr);
        ent_t e;
        e.c = c; e.irv = m_ir; e.cnt = 2'(m_instret % 4);
        e.ir_rdy = ir_rdy; e.m_rdy = m_rdy; e.z = z; e.instr = instr;
        q.push_back(e);
    endtask

    task automatic halt_tail();
        for (int k = 0; k < 3; k++) push(mk(4'hF), rb(), rb(), rb(), $urandom);
    endtask

    // Expand one instruction into its expected cycles, starting in FETCH.
    // fd/md are the number of cycles the fetch/memory ready stays low.
    task automatic build(input logic [31:0] w, input int fd, input int md, input logic z);
        ctl_t c;
        logic [6:0] op;
        logic [2:0] f3;
        logic ld, st, rr, ii, br;
        op = w[6:0];
        f3 = w[14:12];
        ld = (op == 7'b0000011);
        st = (op == 7'b0100011);
        rr = (op == 7'b0110011);
        ii = (op == 7'b0010011);
        br = (op == 7'b1100011) && (f3 == 3'd0 || f3 == 3'd1);
        m_pcsrc = 1'b0;
        for (int k = 0; k <= fd; k++) begin
            c = mk(4'h1); c.ird = 1'b1;
            if (k == fd) begin
                push(c, 1'b1, rb(), rb(), w);
                m_ir = w;
            end else begin
                push(c, 1'b0, rb(), rb(), $urandom);
                if (k + 1 == LIM) begin m_erro = 1'b1; halt_tail(); return; end
            end
        end
        push(mk(4'h2), rb(), rb(), rb(), $urandom);
        if (!(ld || st || rr || ii || br)) begin halt_tail(); return; end
        if (br) begin
            c = mk(4'h7); c.aop = 2'b01;
            push(c, rb(), rb(), z, $urandom);
            m_pcsrc = (f3 == 3'd0) ? z : ~z;
        end else begin
            c = mk(4'h3); c.asrc = !rr; c.aop = (ld || st) ? 2'b00 : 2'b10;
            push(c, rb(), rb(), rb(), $urandom);
            if (ld || st) begin
                for (int k = 0; k <= md; k++) begin
                    c = mk(ld ? 4'h4 : 4'h5); c.mrd = ld; c.mwr = st;
                    if (k == md) begin
                        push(c, rb(), 1'b1, rb(), $urandom);
                    end else begin
                        push(c, rb(), 1'b0, rb(), $urandom);
                        if (k + 1 == LIM) begin m_erro = 1'b1; halt_tail(); return; end
                    end
                end
            end
            if (!st) begin
                c = mk(4'h6); c.rwr = 1'b1; c.m2r = ld;
                push(c, rb(), rb(), rb(), $urandom);
            end
        end
        push(mk(4'h8), rb(), rb(), rb(), $urandom);
        m_instret = m_instret + 1;
    endtask

    task automatic play(input int n);
        ent_t e;
        ctl_t obs;
        int   i = 0;
        while (q.size() > 0 && i < n) begin
            e = q.pop_front();
            @(negedge clk);
            instrucao = e.instr; instr_ready = e.ir_rdy; mem_ready = e.m_rdy;
            zero = e.z; start = rb();
            #1;
            obs = observe();
            checks++;
            if (obs !== e.c) begin
                errors++;
                $display("FAIL ctl @%0t observed=%h expected=%h (est %h vs %h)",
                         $time, obs, e.c, obs.est, e.c.est);
            end
            checks++;
            if (ir !== e.irv) begin
                errors++;
                $display("FAIL ir @%0t observed=%h expected=%h", $time, ir, e.irv);
            end
            checks++;
            if (instret !== e.cnt) begin
                errors++;
                $display("FAIL instret @%0t observed=%0d expected=%0d", $time, instret, e.cnt);
            end
            i++;
        end
    endtask

    task automatic play_all();
        play(1000);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (observe() !== ctl_t'(0) || ir !== 32'd0 || instret !== '0) begin
            errors++;
            $display("FAIL reset @%0t ctl=%h ir=%h instret=%0d expected all zero",
                     $time, observe(), ir, instret);
        end
        q.delete();
        m_pcsrc = 1'b0; m_erro = 1'b0; m_instret = 0; m_ir = '0;
        start = 1'b0; instr_ready = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic begin_run();
        @(negedge clk);
        start = 1'b0; instr_ready = rb(); mem_ready = rb();
        #1;
        checks++;
        if (estado !== 4'h0) begin
            errors++;
            $display("FAIL idle_hold observed=%h expected=0", estado);
        end
        @(negedge clk);
        start = 1'b1;
        #1;
        checks++;
        if (estado !== 4'h0) begin
            errors++;
            $display("FAIL idle_start observed=%h expected=0", estado);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 4))
            0: w[6:0] = 7'b0110011;
            1: w[6:0] = 7'b0010011;
            2: w[6:0] = 7'b0000011;
            3: w[6:0] = 7'b0100011;
            default: begin
                w[6:0]   = 7'b1100011;
                w[14:12] = 3'($urandom_range(0, 1));
            end
        endcase
        return w;
    endfunction

    task automatic test_reset();
        #2;
        do_reset();
        $display("test_reset done, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_add();
        begin_run();
        build(32'h002081B3, 0, 0, 1'b0);
        build(32'h00508093, 2, 0, 1'b0);
        play_all();
        $display("test_add done, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_branch();
        build(32'h00208463, 0, 0, 1'b1);
        build(32'h00208463, 0, 0, 1'b0);
        build(32'h00209463, 1, 0, 1'b1);
        build(32'h00209463, 0, 0, 1'b0);
        play_all();
        $display("test_branch done, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_load_store();
        build(32'h0000A103, 0, 3, 1'b0);
        build(32'h0020A023, 0, 1, 1'b0);
        build(32'h0000A103, 1, 0, 1'b0);
        play_all();
        $display("test_load_store done, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            build(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), rb());
            play_all();
        end
        $display("test_random done, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_store_timeout();
        build(32'h0020A023, 0, 1000, 1'b0);
        play_all();
        $display("test_store_timeout done, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_fetch_timeout();
        do_reset();
        begin_run();
        build(32'h002081B3, 1000, 0, 1'b0);
        play_all();
        $display("test_fetch_timeout done, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_illegal();
        do_reset();
        begin_run();
        build(32'h00000000, 0, 0, 1'b0);
        play_all();
        $display("test_illegal done, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        begin_run();
        build(32'h0020A023, 0, 3, 1'b0);
        play(5);
        do_reset();
        $display("test_reset_mid_write done, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_wrap();
        begin_run();
        for (int n = 0; n < 5; n++) build(32'h002081B3, 0, 0, 1'b0);
        play_all();
        build(32'h002081B3, 0, 0, 1'b0);
        play(1);
        q.delete();
        checks++;
        if (instret !== 2'd1) begin
            errors++;
            $display("FAIL wrap observed=%0d expected=1", instret);
        end
        $display("test_wrap done, checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_load_store();
        test_random();
        test_store_timeout();
        test_fetch_timeout();
        test_illegal();
        test_reset_mid_write();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Multicycle control FSM for the RISC-V datapath.
- Drives the 4-bit `estado` bus consumed by the PC-update block, which advances PC when `estado` = 4'b1000.
- Sequences fetch/decode/execute/memory/writeback and produces datapath control strobes.
- Owns `pcsrc`, latched from the ALU `zero` flag, plus memory read/write handshakes and an instruction-retire counter.

Parameters:
- WAIT_LIMIT, 0, max cycles to wait for `instr_ready`/`mem_ready`; 0 = wait forever.
- CNT_W, 32, width of `instret` counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  leave IDLE and begin fetching.
- instrucao  input  32  instruction word from instruction memory.
- instr_ready  input  1  `instrucao` valid this cycle.
- mem_ready  input  1  data memory completed the access.
- zero  input  1  ALU zero flag.
- estado  output  4  current state code.
- instr_read  output  1  instruction fetch request.
- mem_read  output  1  data memory read request.
- mem_write  output  1  data memory write request.
- reg_write  output  1  register file write enable.
- alu_src  output  1  0 = rs2, 1 = immediate.
- mem_to_reg  output  1  writeback source: 1 = memory, 0 = ALU.
- alu_op  output  2  00 add, 01 sub, 10 funct-decoded.
- pcsrc  output  1  0 = PC+1, 1 = PC+imm/4.
- ir  output  32  latched instruction register.
- halted  output  1  FSM in HALT.
- erro  output  1  halt caused by handshake timeout.
- instret  output  CNT_W  retired instruction count.

Behaviour:
- Reset (async, `rst_n`=0):
  - `estado` = 0000; `ir`, `pcsrc`, `instret`, `halted`, `erro` = 0.
  - All combinational strobes = 0.
  - Reset mid-instruction aborts immediately; no partial write survives, since strobes drop with the state.
- State codes and transitions (registered, one transition per clk edge):
  - 0000 IDLE: `start` = 1 -> FETCH.
  - 0001 FETCH: `instr_read` = 1; `pcsrc` <= 0. On `instr_ready`: `ir` <= `instrucao`, -> DECODE. Otherwise stay.
  - 0010 DECODE: opcode = `ir`[6:0].
    - 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE -> EXECUTE.
    - 1100011 with funct3 000/001 -> BRANCH.
    - Anything else -> HALT.
  - 0011 EXECUTE:
    - R: `alu_src` = 0, `alu_op` = 10.
    - I-ALU: `alu_src` = 1, `alu_op` = 10.
    - LOAD/STORE: `alu_src` = 1, `alu_op` = 00.
    - Next: LOAD -> MEM_READ, STORE -> MEM_WRITE, R/I -> WRITEBACK.
  - 0100 MEM_READ: `mem_read` = 1 (level). On `mem_ready` -> WRITEBACK with `mem_to_reg` = 1.
  - 0101 MEM_WRITE: `mem_write` = 1 (level). On `mem_ready` -> PC_UPDATE.
  - 0110 WRITEBACK: `reg_write` = 1 for exactly this cycle. `mem_to_reg` = 1 iff opcode LOAD. -> PC_UPDATE.
  - 0111 BRANCH: `alu_src` = 0, `alu_op` = 01. `pcsrc` <= (funct3 == 000) ? `zero` : ~`zero`. -> PC_UPDATE.
  - 1000 PC_UPDATE: `instret` += 1, wrapping at 2^CNT_W. -> FETCH.
  - 1111 HALT: absorbing until reset; `halted` = 1; `start` ignored.
- `pcsrc` is registered:
  - Stable through the whole PC_UPDATE cycle.
  - Cleared on the FETCH entry edge.
  - Non-branch instructions always reach PC_UPDATE with `pcsrc` = 0.
- Every instruction passes through 1000 exactly once, so PC advances exactly once per retired instruction.
- Timeout (WAIT_LIMIT > 0):
  - Wait counter is cleared on entry to FETCH/MEM_READ/MEM_WRITE and increments each cycle the ready input is low.
  - When the count reaches WAIT_LIMIT with ready still low: -> HALT, `erro` <= 1.
  - `mem_ready` arriving in the same cycle as the limit wins (normal transition).
- Ready inputs are ignored outside their wait states.
- Latency per instruction, ready = 1 immediately:
  - R/I: 5 cycles.
  - LOAD: 6 cycles.
  - STORE: 5 cycles.
  - Branch: 4 cycles.

Decomposition:
- Shared package `riscv_ctrl_pkg`:
  - state code constants: IDLE, FETCH, DECODE, EXECUTE, MEM_READ, MEM_WRITE, WRITEBACK, BRANCH, PC_UPDATE = 4'b1000, HALT = 4'b1111.
  - opcode constants.
  - `alu_op` encodings.
- PC-update and ALU-control blocks import the same constants.
- One natural sub-module: `decodifica_opcode`, combinational opcode -> instruction class + illegal flag.
- FSM, counters and output decode stay in the top module.

Test Plan:
- Reset then `start`, `ir` = add x3,x1,x2 (0x002081B3), ready tied 1 -> `estado` sequence 0000,0001,0010,0011,0110,1000,0001; `reg_write` high 1 cycle; `pcsrc` = 0; `instret` = 1.
- beq (0x00208463) with `zero` = 1 -> `pcsrc` = 1 throughout `estado` = 1000; with `zero` = 0 -> `pcsrc` = 0; bne inverts both cases.
- lw with `mem_ready` delayed 3 cycles -> `mem_read` held 4 cycles in 0100; then 0110 with `mem_to_reg` = 1 and `reg_write` = 1.
- WAIT_LIMIT = 4, sw with `mem_ready` never asserted -> after 4 cycles in 0101, `estado` = 1111, `halted` = 1, `erro` = 1; `instret` unchanged.
- `instrucao` = 0x00000000 -> DECODE -> 1111 with `erro` = 0; `start` pulses ignored.
- `rst_n` asserted during MEM_WRITE -> `mem_write` drops asynchronously and all outputs return to reset values; CNT_W = 2 run of 5 instructions -> `instret` wraps to 1.
